// File: rtl/csd_pkg.sv
// Signed-digit (CSD) encoding shared by the CSD arithmetic blocks.
// Each digit is two bits: a plus bit and a minus bit, value = plus - minus.
package csd_pkg;

   localparam logic [1:0] CSD_ZERO = 2'b00;
   localparam logic [1:0] CSD_POS  = 2'b10;
   localparam logic [1:0] CSD_NEG  = 2'b01;
   localparam logic [1:0] CSD_INV  = 2'b11;

   localparam int CSD_PLUS_BIT  = 1;
   localparam int CSD_MINUS_BIT = 0;

endpackage

// File: rtl/csd2bin_chunk.sv
// Resolves K signed digits to K binary bits: y = P + ~N + cin over K bits.
module csd2bin_chunk
   import csd_pkg::*;
#(
   parameter int K = 2
) (
   input  logic [2*K-1:0] digits,
   input  logic           cin,
   output logic [K-1:0]   y,
   output logic           cout
);

   logic [K-1:0] p;
   logic [K-1:0] n;
   logic [K:0]   sum;

   always_comb begin
      p = '0;
      n = '0;
      for (int i = 0; i < K; i++) begin
         p[i] = digits[2*i+CSD_PLUS_BIT];
         n[i] = digits[2*i+CSD_MINUS_BIT];
      end
   end

   // An invalid 11 digit gives p=1, ~n=0 here, i.e. the same as a zero digit.
   assign sum  = {1'b0, p} + {1'b0, ~n} + {{K{1'b0}}, cin};
   assign y    = sum[K-1:0];
   assign cout = sum[K];

endmodule

// File: rtl/csd2bin_serial.sv
// Digit-serial CSD to two's-complement converter, K digits per clock.
// Handshake: a transfer happens on a rising edge where valid and ready are both high.
module csd2bin_serial
   import csd_pkg::*;
#(
   parameter int W = 8,
   parameter int K = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [2*W-1:0] in_x,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W:0]   out_y
);

   localparam int NCHUNK = (K > 0) ? W / K : 1;
   localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [CW-1:0] LAST_CHUNK = CW'(NCHUNK - 1);

   generate
      if (W < 1 || K < 1 || (W % K) != 0) begin : g_bad_params
         $error("csd2bin_serial: W must be >= 1 and a multiple of K");
      end
   endgenerate

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t          state_q;
   state_t          state_d;
   logic [2*W-1:0]  op_q;
   logic [W-1:0]    res_q;
   logic            carry_q;
   logic [CW-1:0]   cnt_q;

   logic [K-1:0]    chunk_y;
   logic            chunk_cout;
   logic [W+K-1:0]  res_shift;

   csd2bin_chunk #(.K(K)) u_chunk (
      .digits (op_q[2*K-1:0]),
      .cin    (carry_q),
      .y      (chunk_y),
      .cout   (chunk_cout)
   );

   // New bits enter at the top so the first chunk ends up in the LSBs.
   assign res_shift = {chunk_y, res_q};

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (in_valid) state_d = CONV;
         CONV:    if (cnt_q == LAST_CHUNK) state_d = DONE;
         DONE:    if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         op_q    <= '0;
         res_q   <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  op_q    <= in_x;
                  carry_q <= 1'b1;
                  cnt_q   <= '0;
               end
            end
            CONV: begin
               res_q   <= res_shift[W+K-1:K];
               op_q    <= op_q >> (2*K);
               carry_q <= chunk_cout;
               cnt_q   <= cnt_q + CW'(1);
            end
            default: ;
         endcase
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   // The final carry is the borrow-free flag of P - N, so its inverse is the sign.
   assign out_y     = (state_q == DONE) ? {~carry_q, res_q} : '0;

endmodule
